uart_cmd_parser: RTL

Frame parser and command dispatcher between the UART receive path and the capture-card control logic (ADC, IIC, SPI, trigger). It consumes the byte stream produced by the UART driver, recognises frames of the form head / type / length / payload, and presents each complete command as one parallel word with a valid/ready handshake. Malformed and stalled frames are discarded and flagged, so downstream controllers only ever see whole, length-checked commands.

---
 rtl/uart_cmd_parser.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns the UART byte stream (head/type/len/payload) into
// length-checked parallel commands with valid/ready, flagging bad and stalled frames.
module uart_cmd_parser #(
   parameter logic [7:0] P_HEAD    = 8'h55,
   parameter int         P_MAX_LEN = 4,
   parameter int         P_TIMEOUT = 50000
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [7:0]             i_rx_data,
   input  logic                   i_rx_valid,
   output logic [7:0]             o_cmd_type,
   output logic [7:0]             o_cmd_len,
   output logic [8*P_MAX_LEN-1:0] o_cmd_data,
   output logic                   o_cmd_valid,
   input  logic                   i_cmd_ready,
   output logic                   o_err_len,
   output logic                   o_err_timeout,
   output logic                   o_drop
);
   localparam int TW = $clog2(P_TIMEOUT);
   localparam int CW = $clog2(P_MAX_LEN + 1);
   localparam logic [TW-1:0] TMAX = TW'(P_TIMEOUT - 1);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_TYPE = 3'd1;
   localparam logic [2:0] S_LEN  = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;

   logic [2:0]             state_q, state_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [7:0]             type_q, type_d, len_q, len_d;
   logic [8*P_MAX_LEN-1:0] data_q, data_d;
   logic                   err_len_q, err_len_d, err_tmo_q, err_tmo_d, drop_q, drop_d;
   logic                   in_frame, len_ok, last;

   assign in_frame = (state_q == S_TYPE) || (state_q == S_LEN) || (state_q == S_DATA);
   assign len_ok   = (i_rx_data != 8'd0) && (i_rx_data <= 8'(P_MAX_LEN));
   assign last     = (8'(cnt_q) + 8'd1) == len_q;

   always_comb begin
      state_d   = state_q;
      tmo_d     = '0;
      cnt_d     = cnt_q;
      type_d    = type_q;
      len_d     = len_q;
      data_d    = data_q;
      err_len_d = 1'b0;
      err_tmo_d = 1'b0;
      drop_d    = 1'b0;
      case (state_q)
         S_IDLE: if (i_rx_valid && i_rx_data == P_HEAD) state_d = S_TYPE;
         S_TYPE: if (i_rx_valid) begin
            type_d  = i_rx_data;
            state_d = S_LEN;
         end
         S_LEN: if (i_rx_valid) begin
            if (len_ok) begin
               len_d   = i_rx_data;
               data_d  = '0;
               cnt_d   = '0;
               state_d = S_DATA;
            end else begin
               err_len_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_DATA: if (i_rx_valid) begin
            data_d[8*int'(cnt_q) +: 8] = i_rx_data;
            cnt_d = cnt_q + 1'b1;
            if (last) state_d = S_OUT;
         end
         S_OUT: begin
            drop_d = i_rx_valid;
            if (i_cmd_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // a byte in the expiry cycle wins, so the timeout only fires on an idle cycle
      if (in_frame && !i_rx_valid) begin
         tmo_d = tmo_q + 1'b1;
         if (tmo_q == TMAX) begin
            tmo_d     = '0;
            err_tmo_d = 1'b1;
            state_d   = S_IDLE;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         tmo_q     <= '0;
         cnt_q     <= '0;
         type_q    <= '0;
         len_q     <= '0;
         data_q    <= '0;
         err_len_q <= 1'b0;
         err_tmo_q <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         cnt_q     <= cnt_d;
         type_q    <= type_d;
         len_q     <= len_d;
         data_q    <= data_d;
         err_len_q <= err_len_d;
         err_tmo_q <= err_tmo_d;
         drop_q    <= drop_d;
      end
   end

   assign o_cmd_type    = type_q;
   assign o_cmd_len     = len_q;
   assign o_cmd_data    = data_q;
   assign o_cmd_valid   = state_q == S_OUT;
   assign o_err_len     = err_len_q;
   assign o_err_timeout = err_tmo_q;
   assign o_drop        = drop_q;
endmodule
